// File: rtl/bcd_seg_display_pkg.sv
// Shared types and constants for the BCD 7-segment display driver.
package bcd_seg_display_pkg;

  // Conversion sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_COMMIT
  } state_t;

  // Active-high segment patterns, bit0 = a .. bit6 = g.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Largest value representable in n_dig decimal digits (10^n_dig - 1).
  function automatic int unsigned max_decimal(input int unsigned n_dig);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n_dig; i++) r = r * 10;
    return r - 1;
  endfunction

  // Active-high pattern for one BCD nibble; non-decimal codes show nothing.
  function automatic logic [6:0] seg_digit(input logic [3:0] nib);
    logic [6:0] r;
    r = SEG_OFF;
    for (int i = 0; i < 10; i++) begin
      if (nib == 4'(i)) r = SEG_DIGIT[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_seg_display_dd.sv
// One-channel serial double-dabble engine: one input bit per cycle.
// done is high on the final shift cycle; bcd is complete from the next
// cycle and stays stable until the next start.
module bcd_dd_serial #(
  parameter int VALUE_W = 10,
  parameter int N_DIG   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [VALUE_W-1:0]   bin,
  output logic                 done,
  output logic [N_DIG*4-1:0]   bcd
);

  localparam int BCD_W = N_DIG * 4;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Load on start, otherwise add-3 correct every nibble and shift in the next bit.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    adj   = bcd_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(VALUE_W);
    end else if (cnt_q != '0) begin
      // Digits above N_DIG fall off the top; overflow is flagged separately.
      bcd_d = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Shift counter is control and is reset; the shift registers are reloaded by start.
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
    bin_q <= bin_d;
    bcd_q <= bcd_d;
  end

  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_seg_display.sv
// Multi-channel result display driver: serial binary-to-BCD per channel,
// staged results committed atomically to registered 7-segment outputs.
module bcd_seg_display
  import bcd_seg_display_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int VALUE_W        = 10,
  parameter int N_DIG          = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int LZB            = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*VALUE_W-1:0]   in_values,
  input  logic                      disp_en,
  output logic                      busy,
  output logic                      out_update,
  output logic [N_CH-1:0]           ovf_o,
  output logic [N_CH*N_DIG*7-1:0]   seg_o
);

  localparam int          BCD_W   = N_DIG * 4;
  localparam int          SEG_W   = N_CH * N_DIG * 7;
  localparam int          CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MAXV    = max_decimal(N_DIG);
  localparam logic [6:0]  SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [VALUE_W-1:0] vals_q [N_CH];
  logic [VALUE_W-1:0] vals_d [N_CH];
  logic               cur_ovf_q, cur_ovf_d;
  logic [BCD_W-1:0]   stage_bcd_q [N_CH];
  logic [BCD_W-1:0]   stage_bcd_d [N_CH];
  logic [N_CH-1:0]    stage_ovf_q, stage_ovf_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [N_CH-1:0]    ovf_q, ovf_d;
  logic               upd_q, upd_d;

  logic               dd_start;
  logic               dd_done;
  logic [BCD_W-1:0]   dd_bcd;

  logic               nz;
  logic [3:0]         nib;
  logic [6:0]         pat;

  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign busy     = !in_ready;
  assign dd_start = (state_q == ST_LOAD);

  bcd_dd_serial #(
    .VALUE_W (VALUE_W),
    .N_DIG   (N_DIG)
  ) u_dd (
    .clock (clock),
    .reset (reset),
    .start (dd_start),
    .bin   (vals_q[ch_q]),
    .done  (dd_done),
    .bcd   (dd_bcd)
  );

  // Sequencer: capture inputs, walk channels through load/shift/store, then commit.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    vals_d      = vals_q;
    cur_ovf_d   = cur_ovf_q;
    stage_bcd_d = stage_bcd_q;
    stage_ovf_d = stage_ovf_q;
    upd_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int c = 0; c < N_CH; c++) vals_d[c] = in_values[c*VALUE_W +: VALUE_W];
          ch_d    = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cur_ovf_d = (32'(vals_q[ch_q]) > MAXV);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (dd_done) state_d = ST_STORE;
      end
      ST_STORE: begin
        stage_bcd_d[ch_q] = dd_bcd;
        stage_ovf_d[ch_q] = cur_ovf_q;
        if (ch_q == CH_W'(N_CH - 1)) begin
          // Output registers load on this edge so they are new during COMMIT.
          upd_d   = 1'b1;
          state_d = ST_COMMIT;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Encode staged digits with overflow dashes, leading-zero blanking and polarity.
  always_comb begin
    seg_d = seg_q;
    ovf_d = ovf_q;
    nz    = 1'b0;
    nib   = '0;
    pat   = SEG_OFF;
    if (upd_d) begin
      for (int c = 0; c < N_CH; c++) begin
        ovf_d[c] = stage_ovf_d[c];
        nz       = 1'b0;
        for (int d = N_DIG - 1; d >= 0; d--) begin
          nib = stage_bcd_d[c][d*4 +: 4];
          if (nib != 4'd0 || d == 0) nz = 1'b1;
          if (stage_ovf_d[c])          pat = SEG_DASH;
          else if (LZB != 0 && !nz)    pat = SEG_OFF;
          else                         pat = seg_digit(nib);
          seg_d[(c*N_DIG+d)*7 +: 7] = pat ^ SEG_POL;
        end
      end
    end
  end

  // Control and visible output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      cur_ovf_q <= 1'b0;
      seg_q     <= {(N_CH*N_DIG){SEG_POL}};
      ovf_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cur_ovf_q <= cur_ovf_d;
      seg_q     <= seg_d;
      ovf_q     <= ovf_d;
      upd_q     <= upd_d;
    end
  end

  // NOTE: captured values and staging are always written before being read, so they carry no reset.
  always_ff @(posedge clock) begin
    vals_q      <= vals_d;
    stage_bcd_q <= stage_bcd_d;
    stage_ovf_q <= stage_ovf_d;
  end

  assign out_update = upd_q;
  assign ovf_o      = ovf_q;
  assign seg_o      = disp_en ? seg_q : {(N_CH*N_DIG){SEG_POL}};

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench: LZB=0 and LZB=1 instances side by side, checked
// against an arithmetic decimal-digit model.
module tb_bcd_seg_display;

  localparam int N_CH    = 2;
  localparam int VALUE_W = 10;
  localparam int N_DIG   = 3;
  localparam int SEG_W   = N_CH * N_DIG * 7;
  localparam int MAXV    = 999;
  localparam int LAT     = N_CH * (VALUE_W + 2) + 1;

  localparam logic [6:0] PAT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic [N_CH*VALUE_W-1:0] in_values;
  logic                    disp_en;

  logic             in_ready_a, busy_a, upd_a;
  logic [N_CH-1:0]  ovf_a;
  logic [SEG_W-1:0] seg_a;
  logic             in_ready_b, busy_b, upd_b;
  logic [N_CH-1:0]  ovf_b;
  logic [SEG_W-1:0] seg_b;

  int n_checks = 0;
  int n_fail   = 0;

  int  disp_x, disp_y;
  bit  disp_valid;

  always #5 clock = ~clock;

  bcd_seg_display #(
    .N_CH(N_CH), .VALUE_W(VALUE_W), .N_DIG(N_DIG), .SEG_ACTIVE_LOW(1), .LZB(0)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_values(in_values), .disp_en(disp_en), .busy(busy_a), .out_update(upd_a),
    .ovf_o(ovf_a), .seg_o(seg_a)
  );

  bcd_seg_display #(
    .N_CH(N_CH), .VALUE_W(VALUE_W), .N_DIG(N_DIG), .SEG_ACTIVE_LOW(1), .LZB(1)
  ) dut_lzb (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_values(in_values), .disp_en(disp_en), .busy(busy_b), .out_update(upd_b),
    .ovf_o(ovf_b), .seg_o(seg_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Active-low pattern word for one channel, from decimal arithmetic on the value.
  function automatic logic [N_DIG*7-1:0] ref_ch(input int v, input bit lzb);
    logic [N_DIG*7-1:0] r;
    logic [6:0]         p7;
    int                 p;
    p = 1;
    r = '0;
    for (int d = 0; d < N_DIG; d++) begin
      if (v > MAXV)                   p7 = 7'h40;
      else if (lzb && d > 0 && v < p) p7 = 7'h00;
      else                            p7 = PAT[(v / p) % 10];
      r[d*7 +: 7] = ~p7;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check_display(input string tag);
    logic [SEG_W-1:0] ea, eb;
    logic [N_CH-1:0]  eo;
    if (disp_valid) begin
      ea = {ref_ch(disp_y, 1'b0), ref_ch(disp_x, 1'b0)};
      eb = {ref_ch(disp_y, 1'b1), ref_ch(disp_x, 1'b1)};
      eo = {disp_y > MAXV, disp_x > MAXV};
    end else begin
      ea = '1;
      eb = '1;
      eo = '0;
    end
    if (!disp_en) begin
      ea = '1;
      eb = '1;
    end
    check({tag, ".seg"},     64'(seg_a), 64'(ea));
    check({tag, ".seg_lzb"}, 64'(seg_b), 64'(eb));
    check({tag, ".ovf"},     64'(ovf_a), 64'(eo));
    check({tag, ".ovf_lzb"}, 64'(ovf_b), 64'(eo));
  endtask

  task automatic start_accept(input int x, input int y);
    int n;
    n = 0;
    while (in_ready_a !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("accept.in_ready", 64'(in_ready_a), 64'(1));
    in_values = {10'(y), 10'(x)};
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  // Called in cycle lat0 after the accept edge; returns in the cycle after out_update.
  task automatic wait_update(input int nx, input int ny, input int lat0);
    int lat;
    lat = lat0;
    while (upd_a !== 1'b1 && lat < 200) begin
      check_display("hold");
      check("hold.busy", 64'(busy_a), 64'(1));
      check("hold.upd_lzb", 64'(upd_b), 64'(0));
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(LAT));
    check("upd_lzb", 64'(upd_b), 64'(1));
    disp_x     = nx;
    disp_y     = ny;
    disp_valid = 1'b1;
    check_display("result");
    step();
    check("upd_pulse", 64'(upd_a), 64'(0));
    check("idle.in_ready", 64'(in_ready_a), 64'(1));
    check("idle.busy", 64'(busy_a), 64'(0));
  endtask

  initial begin
    int x, y;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_values  = '0;
    disp_en    = 1'b1;
    disp_valid = 1'b0;
    disp_x     = 0;
    disp_y     = 0;

    // Reset state
    step();
    step();
    check("rst.in_ready", 64'(in_ready_a), 64'(0));
    check_display("rst");
    reset = 1'b0;
    step();
    check("rst.ready_after", 64'(in_ready_a), 64'(1));
    check("rst.busy", 64'(busy_a), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check("rst.no_update", 64'(upd_a | upd_b), 64'(0));
      step();
    end
    check_display("rst.idle");

    // Nominal values, then overflow and small-value / leading-zero cases
    start_accept(639, 479);
    wait_update(639, 479, 1);
    start_accept(1000, 0);
    wait_update(1000, 0, 1);
    start_accept(5, 0);
    wait_update(5, 0, 1);
    start_accept(999, 40);
    wait_update(999, 40, 1);

    // in_valid held through busy with changing values, disp_en blanking
    check("hold5.in_ready", 64'(in_ready_a), 64'(1));
    in_values = {10'd12, 10'd345};
    in_valid  = 1'b1;
    step();
    in_values = {10'd807, 10'd60};
    wait_update(345, 12, 1);
    check("second_accept.in_ready", 64'(in_ready_a), 64'(1));
    step();
    in_valid = 1'b0;
    check("second.busy", 64'(busy_a), 64'(1));
    step();
    disp_en = 1'b0;
    #1;
    check_display("blank");
    disp_en = 1'b1;
    #1;
    check_display("unblank");
    wait_update(60, 807, 2);
    disp_en = 1'b0;
    #1;
    check_display("blank2");
    disp_en = 1'b1;
    #1;
    check_display("unblank2");

    // Reset ten cycles into a conversion
    start_accept(123, 456);
    for (int i = 1; i < 10; i++) step();
    reset = 1'b1;
    step();
    disp_valid = 1'b0;
    check("midrst.in_ready", 64'(in_ready_a), 64'(0));
    check("midrst.upd", 64'(upd_a | upd_b), 64'(0));
    check_display("midrst");
    reset = 1'b0;
    step();
    check("midrst.ready_after", 64'(in_ready_a), 64'(1));
    for (int i = 0; i < 30; i++) begin
      check("midrst.no_update", 64'(upd_a | upd_b), 64'(0));
      step();
    end
    check_display("midrst.idle");

    // Random values
    for (int k = 0; k < 12; k++) begin
      x = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) y = int'($urandom_range(0, 20));
      else                           y = int'($urandom_range(0, 1023));
      start_accept(x, y);
      wait_update(x, y, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
